count_sequencer: RTL and testbench

- Run/pause/clear controller for the 4-bit decade counter datapath that drives the board LEDs and buzzer.
- Synchronizes three push-button requests and divides the board clock into count ticks.
- Issues single-cycle increment and clear strobes to the counter datapath.
- Times the buzzer alarm on every wrap from MAX_COUNT back to 0.

---
 rtl/count_sequencer.sv | 122 ++++++++++++
 tb/tb_count_sequencer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/count_sequencer.sv
// Run/pause/clear sequencer for the decade counter: synchronizes buttons, divides CLK
// into count ticks, issues inc/clr strobes and times the buzzer after each wrap.
module count_sequencer #(
    parameter int TICK_DIV   = 25000000,
    parameter int MAX_COUNT  = 9,
    parameter int BEEP_TICKS = 2
) (
    input  logic       CLK,
    input  logic       rst,
    input  logic       btn_start,
    input  logic       btn_pause,
    input  logic       btn_clear,
    input  logic [3:0] cnt_val,
    output logic       cnt_inc,
    output logic       cnt_clr,
    output logic       beep,
    output logic       running,
    output logic [1:0] state
);

    localparam int DIV_W = $clog2(TICK_DIV);
    localparam int BL_W  = $clog2(BEEP_TICKS + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        ALARM = 2'd3
    } state_t;

    state_t            state_q;
    logic [DIV_W-1:0]  div_cnt;
    logic [BL_W-1:0]   beep_left;
    logic [2:0]        btn_s1, btn_s2, btn_prev;
    logic [2:0]        btn_evt;
    logic              clr_evt, pause_evt, start_evt;
    logic              active, tick_due, wrap;

    // Bit order {clear, pause, start}; an event is the first cycle the synchronized level is high.
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            btn_s1   <= '0;
            btn_s2   <= '0;
            btn_prev <= '0;
        end else begin
            btn_s1   <= {btn_clear, btn_pause, btn_start};
            btn_s2   <= btn_s1;
            btn_prev <= btn_s2;
        end
    end

    assign btn_evt   = btn_s2 & ~btn_prev;
    assign clr_evt   = btn_evt[2];
    assign pause_evt = btn_evt[1];
    assign start_evt = btn_evt[0];
    assign active    = (state_q == RUN) || (state_q == ALARM);
    assign tick_due  = (div_cnt == DIV_W'(TICK_DIV - 1));
    assign wrap      = (cnt_val >= 4'(MAX_COUNT));

    // Any button event takes the cycle, so the divider holds and a due tick is deferred.
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            div_cnt   <= '0;
            beep_left <= '0;
            cnt_inc   <= 1'b0;
            cnt_clr   <= 1'b0;
            beep      <= 1'b0;
        end else begin
            cnt_inc <= 1'b0;
            cnt_clr <= 1'b0;
            if (clr_evt) begin
                cnt_clr   <= 1'b1;
                div_cnt   <= '0;
                beep_left <= '0;
                beep      <= 1'b0;
                state_q   <= IDLE;
            end else if (pause_evt) begin
                if (active) begin
                    state_q <= PAUSE;
                    beep    <= 1'b0;
                end
            end else if (start_evt) begin
                if (state_q == IDLE) begin
                    state_q <= RUN;
                end else if (state_q == PAUSE) begin
                    if (beep_left != '0) begin
                        state_q <= ALARM;
                        beep    <= 1'b1;
                    end else begin
                        state_q <= RUN;
                    end
                end
            end else if (active) begin
                if (tick_due) begin
                    div_cnt <= '0;
                    if (wrap) begin
                        cnt_clr   <= 1'b1;
                        beep_left <= BL_W'(BEEP_TICKS);
                        state_q   <= ALARM;
                        beep      <= 1'b1;
                    end else begin
                        cnt_inc <= 1'b1;
                        if (state_q == ALARM) begin
                            beep_left <= beep_left - BL_W'(1);
                            if (beep_left == BL_W'(1)) begin
                                state_q <= RUN;
                                beep    <= 1'b0;
                            end
                        end
                    end
                end else begin
                    div_cnt <= div_cnt + DIV_W'(1);
                end
            end
        end
    end

    assign running = (state_q == RUN) || (state_q == ALARM);
    assign state   = state_q;

endmodule

// File: tb/tb_count_sequencer.sv
// Directed bench for count_sequencer with TICK_DIV=4, MAX_COUNT=9, BEEP_TICKS=2.
module tb_count_sequencer;

    logic       CLK = 1'b0;
    logic       rst;
    logic       btn_start, btn_pause, btn_clear;
    logic [3:0] cnt_val;
    logic       cnt_inc, cnt_clr, beep, running;
    logic [1:0] state;

    int tests_run = 0;
    int tests_failed = 0;

    count_sequencer #(.TICK_DIV(4), .MAX_COUNT(9), .BEEP_TICKS(2)) dut (
        .CLK(CLK), .rst(rst),
        .btn_start(btn_start), .btn_pause(btn_pause), .btn_clear(btn_clear),
        .cnt_val(cnt_val),
        .cnt_inc(cnt_inc), .cnt_clr(cnt_clr), .beep(beep),
        .running(running), .state(state)
    );

    always #5 CLK = ~CLK;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, then settle 1ns past the last one.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic apply_stimulus(input logic s, input logic p, input logic c);
        btn_start = s;
        btn_pause = p;
        btn_clear = c;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int strobes;
        int run_cycles;
        int waited;
        rst = 1'b0;
        cnt_val = 4'd0;
        apply_stimulus(1'b0, 1'b0, 1'b0);
        step(2);
        check_output("reset_state", 32'(state), 32'd0);
        check_output("reset_inc", 32'(cnt_inc), 32'd0);
        check_output("reset_clr", 32'(cnt_clr), 32'd0);
        check_output("reset_beep", 32'(beep), 32'd0);
        check_output("reset_running", 32'(running), 32'd0);
        rst = 1'b1;
        step(1);

        // Start from IDLE: RUN appears on the third edge after the press.
        apply_stimulus(1'b1, 1'b0, 1'b0);
        step(2);
        check_output("start_latency_e1", 32'(state), 32'd0);
        step(1);
        check_output("start_run", 32'(state), 32'd1);
        check_output("start_running", 32'(running), 32'd1);
        apply_stimulus(1'b0, 1'b0, 1'b0);
        step(3);
        check_output("inc_not_yet", 32'(cnt_inc), 32'd0);
        step(1);
        check_output("inc_first", 32'(cnt_inc), 32'd1);
        check_output("run_beep0", 32'(beep), 32'd0);
        step(1);
        check_output("inc_one_cycle", 32'(cnt_inc), 32'd0);
        step(3);
        check_output("inc_second", 32'(cnt_inc), 32'd1);

        // Wrap from 9: clear strobe, ALARM, beep for two ticks.
        cnt_val = 4'd9;
        step(4);
        check_output("wrap_clr", 32'(cnt_clr), 32'd1);
        check_output("wrap_no_inc", 32'(cnt_inc), 32'd0);
        check_output("wrap_alarm", 32'(state), 32'd3);
        check_output("wrap_beep", 32'(beep), 32'd1);
        cnt_val = 4'd0;
        step(1);
        check_output("wrap_clr_one_cycle", 32'(cnt_clr), 32'd0);
        step(3);
        check_output("alarm_tick1_inc", 32'(cnt_inc), 32'd1);
        check_output("alarm_tick1_state", 32'(state), 32'd3);
        step(3);
        check_output("alarm_beep_last", 32'(beep), 32'd1);
        step(1);
        check_output("alarm_end_state", 32'(state), 32'd1);
        check_output("alarm_end_beep", 32'(beep), 32'd0);
        check_output("alarm_tick2_inc", 32'(cnt_inc), 32'd1);

        // Pause mid-alarm after one tick, hold, then resume into ALARM.
        cnt_val = 4'd9;
        step(4);
        check_output("wrap2_alarm", 32'(state), 32'd3);
        cnt_val = 4'd0;
        step(4);
        check_output("wrap2_tick1", 32'(cnt_inc), 32'd1);
        apply_stimulus(1'b0, 1'b1, 1'b0);
        step(2);
        check_output("pause_pending", 32'(state), 32'd3);
        step(1);
        check_output("pause_state", 32'(state), 32'd2);
        check_output("pause_beep", 32'(beep), 32'd0);
        check_output("pause_running", 32'(running), 32'd0);
        strobes = 0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (cnt_inc || cnt_clr || beep || state != 2'd2) strobes++;
        end
        check_output("pause_hold_quiet", 32'(strobes), 32'd0);
        apply_stimulus(1'b1, 1'b0, 1'b0);
        step(3);
        check_output("resume_alarm", 32'(state), 32'd3);
        check_output("resume_beep", 32'(beep), 32'd1);
        apply_stimulus(1'b0, 1'b0, 1'b0);
        step(1);
        check_output("resume_beep_hold", 32'(beep), 32'd1);
        step(1);
        check_output("resume_end_run", 32'(state), 32'd1);
        check_output("resume_end_beep", 32'(beep), 32'd0);
        check_output("resume_end_inc", 32'(cnt_inc), 32'd1);

        // Pause lands on the cycle the divider is due: tick deferred to just after resume.
        step(1);
        apply_stimulus(1'b0, 1'b1, 1'b0);
        step(3);
        check_output("pause_due_state", 32'(state), 32'd2);
        check_output("pause_due_no_inc", 32'(cnt_inc), 32'd0);
        apply_stimulus(1'b1, 1'b0, 1'b0);
        step(3);
        check_output("pause_due_resume", 32'(state), 32'd1);
        check_output("pause_due_resume_inc", 32'(cnt_inc), 32'd0);
        apply_stimulus(1'b0, 1'b0, 1'b0);
        step(1);
        check_output("pause_due_first_tick", 32'(cnt_inc), 32'd1);

        // All three buttons together: clear wins.
        apply_stimulus(1'b1, 1'b1, 1'b1);
        step(3);
        check_output("prio_clr", 32'(cnt_clr), 32'd1);
        check_output("prio_no_inc", 32'(cnt_inc), 32'd0);
        check_output("prio_idle", 32'(state), 32'd0);
        check_output("prio_running", 32'(running), 32'd0);
        apply_stimulus(1'b0, 1'b0, 1'b0);
        step(1);
        check_output("prio_clr_one_cycle", 32'(cnt_clr), 32'd0);
        step(2);

        // Held start: one transition; divider restarts from zero after the clear.
        apply_stimulus(1'b1, 1'b0, 1'b0);
        step(2);
        check_output("hold_still_idle", 32'(state), 32'd0);
        step(1);
        check_output("hold_run", 32'(state), 32'd1);
        step(3);
        check_output("hold_div_zero_no_inc", 32'(cnt_inc), 32'd0);
        step(1);
        check_output("hold_div_zero_tick", 32'(cnt_inc), 32'd1);
        run_cycles = 0;
        for (int i = 0; i < 95; i++) begin
            step(1);
            if (state == 2'd1) run_cycles++;
        end
        check_output("hold_single_event", 32'(run_cycles), 32'd95);

        // Reset during an active clear strobe aborts immediately.
        apply_stimulus(1'b0, 1'b0, 1'b0);
        cnt_val = 4'd9;
        waited = 0;
        while (!cnt_clr && waited < 8) begin
            step(1);
            waited++;
        end
        check_output("wrap3_seen", 32'(cnt_clr), 32'd1);
        check_output("wrap3_beep", 32'(beep), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check_output("async_rst_state", 32'(state), 32'd0);
        check_output("async_rst_clr", 32'(cnt_clr), 32'd0);
        check_output("async_rst_inc", 32'(cnt_inc), 32'd0);
        check_output("async_rst_beep", 32'(beep), 32'd0);
        check_output("async_rst_running", 32'(running), 32'd0);
        cnt_val = 4'd0;
        step(1);
        rst = 1'b1;
        step(3);
        check_output("post_rst_idle", 32'(state), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
